// File: rtl/lcd_msg_pkg.sv
// ----------------------------------------------------------------------------
// lcd_msg_pkg
// Shared definitions for the score-driven LCD message sequencer:
//   - leader/status encodings (tie, player 1 ahead, player 2 ahead, nothing displayed)
//   - sequencer FSM state enum
//   - message length and the three 16-character ASCII message strings
//   - msg_char(): picks one character out of a packed message string
// ----------------------------------------------------------------------------
package lcd_msg_pkg;

   localparam logic [1:0] ST_TIE  = 2'b00;
   localparam logic [1:0] ST_P1   = 2'b01;
   localparam logic [1:0] ST_P2   = 2'b10;
   localparam logic [1:0] ST_NONE = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_CLEAR      = 3'd1,
      S_CLEAR_WAIT = 3'd2,
      S_WRITE      = 3'd3,
      S_GAP        = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   localparam int MSG_LEN = 16;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   // Character 0 sits in the most significant byte of each packed string.
   localparam logic [8*MSG_LEN-1:0] MSG_P1_TEXT  = "PLAYER 1 WINNING";
   localparam logic [8*MSG_LEN-1:0] MSG_P2_TEXT  = "PLAYER 2 WINNING";
   localparam logic [8*MSG_LEN-1:0] MSG_TIE_TEXT = {"SCORE IS TIED", ASCII_SPACE, ASCII_SPACE, ASCII_SPACE};

   function automatic logic [7:0] msg_char(input logic [8*MSG_LEN-1:0] text,
                                           input logic [3:0]           idx);
      return text[8*(MSG_LEN - 1 - int'(idx)) +: 8];
   endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// ----------------------------------------------------------------------------
// lcd_msg_rom
// Combinational character lookup for the status messages.
// Ports:
//   i_msg_sel  in  2  message select (status encoding); 11 yields spaces
//   i_idx      in  4  character position 0..15
//   o_char     out 8  ASCII character at that position
// ----------------------------------------------------------------------------
module lcd_msg_rom
   import lcd_msg_pkg::*;
(
   input  logic [1:0] i_msg_sel,
   input  logic [3:0] i_idx,
   output logic [7:0] o_char
);

   // Message select plus position to ASCII byte
   always_comb begin
      o_char = ASCII_SPACE;
      case (i_msg_sel)
         ST_P1:   o_char = msg_char(MSG_P1_TEXT, i_idx);
         ST_P2:   o_char = msg_char(MSG_P2_TEXT, i_idx);
         ST_TIE:  o_char = msg_char(MSG_TIE_TEXT, i_idx);
         default: o_char = ASCII_SPACE;
      endcase
   end

endmodule

// File: rtl/score_lcd_sequencer.sv
// ----------------------------------------------------------------------------
// score_lcd_sequencer
// Compares two player scores and, whenever the leader status differs from
// the message on the LCD, clears the LCD and rewrites a 16-character status
// message one character at a time with pacing gaps.
// Ports:
//   clock          in  1        system clock
//   reset          in  1        asynchronous active-high reset
//   player1_score  in  SCORE_W  unsigned score, player 1
//   player2_score  in  SCORE_W  unsigned score, player 2
//   lcd_clear      out 1        one-cycle clear pulse
//   lcd_write_en   out 1        one-cycle pulse per character
//   lcd_data       out 8        ASCII character, 00 outside writes
//   leader         out 2        displayed status (00 tie, 01 P1, 10 P2, 11 none)
//   busy           out 1        high from CLEAR through the last GAP
//   done           out 1        one-cycle pulse when a message completes
// ----------------------------------------------------------------------------
module score_lcd_sequencer
   import lcd_msg_pkg::*;
#(
   parameter int SCORE_W    = 10,
   parameter int CLEAR_WAIT = 2000,
   parameter int CHAR_GAP   = 500
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [SCORE_W-1:0] player1_score,
   input  logic [SCORE_W-1:0] player2_score,
   output logic               lcd_clear,
   output logic               lcd_write_en,
   output logic [7:0]         lcd_data,
   output logic [1:0]         leader,
   output logic               busy,
   output logic               done
);

   // One shared counter serves both the post-clear wait and the char gap.
   localparam int CNT_MAX = (CLEAR_WAIT > CHAR_GAP) ? CLEAR_WAIT : CHAR_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [3:0]         r_idx;
   logic [1:0]         r_msg_sel;
   logic [1:0]         r_leader;
   logic               r_lcd_clear;
   logic               r_lcd_write_en;
   logic [7:0]         r_lcd_data;
   logic               r_busy;
   logic               r_done;

   state_t             w_state_nx;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic [3:0]         w_idx_nx;
   logic [1:0]         w_msg_sel_nx;
   logic [1:0]         w_leader_nx;
   logic [1:0]         w_live;
   logic [7:0]         w_rom_char;

   // Live leader status from an unsigned full-width compare
   always_comb begin
      w_live = ST_TIE;
      if (player1_score > player2_score) begin
         w_live = ST_P1;
      end else if (player2_score > player1_score) begin
         w_live = ST_P2;
      end else begin
         w_live = ST_TIE;
      end
   end

   // The ROM is addressed with next-state values so the registered
   // character lines up with the cycle the FSM spends in WRITE.
   lcd_msg_rom u_rom (
      .i_msg_sel (w_msg_sel_nx),
      .i_idx     (w_idx_nx),
      .o_char    (w_rom_char)
   );

   // Next-state, counter, index, message-select and leader logic
   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_idx_nx     = r_idx;
      w_msg_sel_nx = r_msg_sel;
      w_leader_nx  = r_leader;
      case (r_state)
         S_IDLE: begin
            if (w_live != r_leader) begin
               w_msg_sel_nx = w_live;
               w_state_nx   = S_CLEAR;
            end else begin
               w_state_nx   = S_IDLE;
            end
         end
         S_CLEAR: begin
            w_state_nx = S_CLEAR_WAIT;
            w_cnt_nx   = '0;
         end
         S_CLEAR_WAIT: begin
            if (r_cnt == CNT_W'(CLEAR_WAIT - 1)) begin
               w_state_nx = S_WRITE;
               w_cnt_nx   = '0;
               w_idx_nx   = 4'd0;
            end else begin
               w_cnt_nx   = r_cnt + CNT_W'(1);
            end
         end
         S_WRITE: begin
            w_state_nx = S_GAP;
            w_cnt_nx   = '0;
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(CHAR_GAP - 1)) begin
               w_cnt_nx = '0;
               // Last-character test comes before any increment, so idx never wraps.
               if (r_idx == 4'(MSG_LEN - 1)) begin
                  w_state_nx = S_DONE;
               end else begin
                  w_idx_nx   = r_idx + 4'd1;
                  w_state_nx = S_WRITE;
               end
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         S_DONE: begin
            w_leader_nx = r_msg_sel;
            w_state_nx  = S_IDLE;
         end
         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // State, datapath and Moore output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_idx          <= 4'd0;
         r_msg_sel      <= ST_TIE;
         r_leader       <= ST_NONE;
         r_lcd_clear    <= 1'b0;
         r_lcd_write_en <= 1'b0;
         r_lcd_data     <= 8'h00;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state        <= w_state_nx;
         r_cnt          <= w_cnt_nx;
         r_idx          <= w_idx_nx;
         r_msg_sel      <= w_msg_sel_nx;
         r_leader       <= w_leader_nx;
         r_lcd_clear    <= (w_state_nx == S_CLEAR);
         r_lcd_write_en <= (w_state_nx == S_WRITE);
         r_lcd_data     <= (w_state_nx == S_WRITE) ? w_rom_char : 8'h00;
         r_busy         <= (w_state_nx == S_CLEAR) || (w_state_nx == S_CLEAR_WAIT) ||
                           (w_state_nx == S_WRITE) || (w_state_nx == S_GAP);
         r_done         <= (w_state_nx == S_DONE);
      end
   end

   assign lcd_clear    = r_lcd_clear;
   assign lcd_write_en = r_lcd_write_en;
   assign lcd_data     = r_lcd_data;
   assign leader       = r_leader;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_score_lcd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_score_lcd_sequencer
// Self-checking bench. The reference model describes each message as a
// timeline of offsets from the IDLE decision cycle (clear at +1, write k at
// +2+CW+k*(CG+1), done at +2+CW+16*(CG+1)) and takes characters from plain
// strings. Outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_score_lcd_sequencer;

   localparam int SW       = 10;
   localparam int CW       = 4;
   localparam int CG       = 3;
   localparam int FIRST_WR = 2 + CW;
   localparam int MSG_T    = 2 + CW + 16 * (CG + 1);

   localparam logic [1:0] L_TIE  = 2'b00;
   localparam logic [1:0] L_P1   = 2'b01;
   localparam logic [1:0] L_P2   = 2'b10;
   localparam logic [1:0] L_NONE = 2'b11;
   localparam logic [13:0] RESET_VEC = {1'b0, 1'b0, 8'h00, 2'b11, 1'b0, 1'b0};

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [SW-1:0] p1 = '0;
   logic [SW-1:0] p2 = '0;
   logic          lcd_clear, lcd_write_en, busy, done;
   logic [7:0]    lcd_data;
   logic [1:0]    leader;

   int            errors = 0;
   int            checks = 0;
   logic [1:0]    m_leader = 2'b11;

   always #5 clock = ~clock;

   score_lcd_sequencer #(.SCORE_W(SW), .CLEAR_WAIT(CW), .CHAR_GAP(CG)) dut (
      .clock         (clock),
      .reset         (reset),
      .player1_score (p1),
      .player2_score (p2),
      .lcd_clear     (lcd_clear),
      .lcd_write_en  (lcd_write_en),
      .lcd_data      (lcd_data),
      .leader        (leader),
      .busy          (busy),
      .done          (done)
   );

   function automatic logic [1:0] live(input logic [SW-1:0] a, input logic [SW-1:0] b);
      if (a > b) return L_P1;
      else if (b > a) return L_P2;
      else return L_TIE;
   endfunction

   function automatic logic [7:0] msg_byte(input logic [1:0] sel, input int k);
      string s;
      if (sel == L_P1) s = "PLAYER 1 WINNING";
      else if (sel == L_P2) s = "PLAYER 2 WINNING";
      else s = "SCORE IS TIED   ";
      return s[k];
   endfunction

   // Expected {clear, write_en, data, leader, busy, done} at offset d from the decision
   function automatic logic [13:0] model(input logic [1:0] sel, input logic [1:0] prev, input int d);
      logic clr, we, bsy, dn;
      logic [7:0] dat;
      logic [1:0] ld;
      clr = (d == 1);
      bsy = (d >= 1) && (d < MSG_T);
      dn  = (d == MSG_T);
      we  = 1'b0;
      dat = 8'h00;
      if (d >= FIRST_WR && d < MSG_T && ((d - FIRST_WR) % (CG + 1)) == 0) begin
         we  = 1'b1;
         dat = msg_byte(sel, (d - FIRST_WR) / (CG + 1));
      end
      ld = (d <= MSG_T) ? prev : sel;
      return {clr, we, dat, ld, bsy, dn};
   endfunction

   function automatic logic [13:0] obs();
      return {lcd_clear, lcd_write_en, lcd_data, leader, busy, done};
   endfunction

   task automatic test_reset();
      logic [13:0] got;
      #2 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         got = obs();
         checks++;
         if (got !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, got, RESET_VEC);
         end
      end
   endtask

   task automatic test_release();
      logic [13:0] got, exp;
      p1 = 10'd0; p2 = 10'd0;
      reset = 1'b0;
      for (int d = 1; d <= MSG_T + 1; d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_TIE, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL release_tie d=%0d got=%h exp=%h", d, got, exp);
         end
      end
      m_leader = L_TIE;
   endtask

   task automatic test_lead_change();
      logic [13:0] got, exp;
      p1 = 10'd5; p2 = 10'd3;
      for (int d = 1; d <= MSG_T + 1; d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_P1, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL lead_change d=%0d got=%h exp=%h", d, got, exp);
         end
      end
      m_leader = L_P1;
   endtask

   task automatic test_no_change();
      logic [13:0] got, exp;
      p1 = 10'd8; p2 = 10'd3;
      exp = model(L_P1, L_P1, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         got = obs();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL no_change cyc=%0d got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_width_boundary();
      logic [13:0] got, exp;
      logic [1:0]  sel;
      for (int m = 0; m < 3; m++) begin
         if (m == 1) begin p1 = 10'd1023; p2 = 10'd1022; end
         else begin p1 = 10'd1022; p2 = 10'd1023; end
         sel = (m == 1) ? L_P1 : L_P2;
         for (int d = 1; d <= MSG_T + 1; d++) begin
            @(negedge clock);
            got = obs(); exp = model(sel, m_leader, d);
            checks++;
            if (got !== exp) begin
               errors++;
               $display("FAIL width_boundary m=%0d d=%0d got=%h exp=%h", m, d, got, exp);
            end
         end
         m_leader = sel;
      end
   endtask

   task automatic test_mid_message_change();
      logic [13:0] got, exp;
      p1 = 10'd5; p2 = 10'd3;
      for (int d = 1; d <= MSG_T + 1; d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_P1, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mid_change_p1 d=%0d got=%h exp=%h", d, got, exp);
         end
         if (d == FIRST_WR + 7 * (CG + 1)) p2 = 10'd9;
      end
      m_leader = L_P1;
      for (int d = 1; d <= MSG_T + 1; d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_P2, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL mid_change_p2 d=%0d got=%h exp=%h", d, got, exp);
         end
      end
      m_leader = L_P2;
   endtask

   task automatic test_reset_mid_message();
      logic [13:0] got, exp;
      p1 = 10'd7; p2 = 10'd7;
      for (int d = 1; d <= FIRST_WR + 10 * (CG + 1); d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_TIE, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_pre d=%0d got=%h exp=%h", d, got, exp);
         end
      end
      reset = 1'b1;
      #1;
      got = obs();
      checks++;
      if (got !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_mid_same_cycle got=%h exp=%h", got, RESET_VEC);
      end
      @(negedge clock);
      reset = 1'b0;
      m_leader = L_NONE;
      for (int d = 1; d <= MSG_T + 1; d++) begin
         @(negedge clock);
         got = obs(); exp = model(L_TIE, m_leader, d);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_replay d=%0d got=%h exp=%h", d, got, exp);
         end
      end
      m_leader = L_TIE;
   endtask

   task automatic test_random();
      logic [13:0] got, exp;
      logic [1:0]  sel;
      int          pd;
      for (int it = 0; it < 12; it++) begin
         if (live(p1, p2) == m_leader) begin
            if ($urandom_range(0, 3) == 0) begin
               p1 = SW'($urandom_range(0, 1023));
               p2 = SW'($urandom_range(0, 1023));
            end else begin
               p1 = SW'($urandom_range(0, 3));
               p2 = SW'($urandom_range(0, 3));
            end
         end
         sel = live(p1, p2);
         pd  = int'($urandom_range(2, MSG_T - 1));
         if (sel == m_leader) begin
            exp = model(sel, m_leader, 0);
            for (int i = 0; i < 3; i++) begin
               @(negedge clock);
               got = obs();
               checks++;
               if (got !== exp) begin
                  errors++;
                  $display("FAIL random_idle it=%0d got=%h exp=%h", it, got, exp);
               end
            end
         end else begin
            for (int d = 1; d <= MSG_T + 1; d++) begin
               @(negedge clock);
               got = obs(); exp = model(sel, m_leader, d);
               checks++;
               if (got !== exp) begin
                  errors++;
                  $display("FAIL random_msg it=%0d d=%0d got=%h exp=%h", it, d, got, exp);
               end
               // Scores moving mid-message must not affect the frozen message.
               if (d == pd) begin
                  p1 = SW'($urandom_range(0, 3));
                  p2 = SW'($urandom_range(0, 3));
               end
            end
            m_leader = sel;
         end
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_lead_change();
      test_no_change();
      test_width_boundary();
      test_mid_message_change();
      test_reset_mid_message();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/score_lcd_sequencer.md
# score_lcd_sequencer

Streams a 16-character status message ("PLAYER 1 WINNING", "PLAYER 2 WINNING" or "SCORE IS TIED") into the character LCD controller.
- Compares the two player scores every cycle.
- Whenever the leader status differs from what is currently displayed, clears the LCD and rewrites it one character at a time, with pacing gaps between writes.
- Sits in the top level between the two processors' score outputs and the lcd instance, replacing the fixed keyboard-letter data path.

## Interface
Parameters:
- SCORE_W, 10, width of each score input.
- CLEAR_WAIT, 2000, cycles to wait after the clear pulse before the first write (must be ≥1).
- CHAR_GAP, 500, idle cycles between consecutive character writes (must be ≥1).

Ports:
- clock  in  1  system clock (10 MHz PLL output).
- reset  in  1  asynchronous, active-high reset.
- player1_score  in  SCORE_W  unsigned score, player 1.
- player2_score  in  SCORE_W  unsigned score, player 2.
- lcd_clear  out  1  one-cycle pulse; ORed into the lcd reset at top level.
- lcd_write_en  out  1  one-cycle pulse per character.
- lcd_data  out  8  ASCII character; valid while lcd_write_en=1.
- leader  out  2  displayed status: 00 tie, 01 player 1 ahead, 10 player 2 ahead, 11 nothing displayed.
- busy  out  1  high from CLEAR through the last GAP.
- done  out  1  one-cycle pulse when a message completes.

## Operation
- Live status, combinational:
  - p1>p2 → 01.
  - p2>p1 → 10.
  - equal → 00.
  - Compare as unsigned.
- FSM states:
  - IDLE: if live status ≠ leader, latch live status into msg_sel and go to CLEAR. Otherwise stay.
  - CLEAR: lcd_clear=1 for one cycle. Go to CLEAR_WAIT with the wait counter = 0.
  - CLEAR_WAIT: count to CLEAR_WAIT−1. Then go to WRITE with idx = 0.
  - WRITE: lcd_write_en=1, lcd_data=ROM(msg_sel, idx). Go to GAP.
  - GAP: count CHAR_GAP cycles. If idx=15, go to DONE; else idx+1, go to WRITE.
  - DONE: done=1, leader ← msg_sel. Go to IDLE.
- msg_sel is frozen for the whole message. Score changes mid-message do not alter the characters being written. After DONE, IDLE re-evaluates and starts a new message if the status has changed again.
- Message strings, all exactly 16 characters:
  - 01 → "PLAYER 1 WINNING".
  - 10 → "PLAYER 2 WINNING".
  - 00 → "SCORE IS TIED" followed by 3 spaces (8'h20).
- lcd_data is 8'h00 outside WRITE.
- The 4-bit idx counter never wraps in normal use. The 15 check happens before any increment.

## Timing
- Reset values (asynchronous): state IDLE, leader=11, lcd_clear=0, lcd_write_en=0, lcd_data=00, busy=0, done=0, all counters 0.
- Because leader resets to 11, the first cycle after reset release always starts a message.
- Cycle numbering, with IDLE detecting a mismatch at cycle t:
  - CLEAR at t+1.
  - Write k at t+2+CLEAR_WAIT+k·(CHAR_GAP+1), for k=0..15.
  - DONE at t+2+CLEAR_WAIT+16·(CHAR_GAP+1).
  - leader updates on the clock edge ending DONE.
- busy is a registered state decode: high in CLEAR, CLEAR_WAIT, WRITE and GAP; low in IDLE and DONE.
- All outputs are Moore outputs; no combinational path from the score inputs to any output.
- Reset asserted mid-message: outputs drop to reset values immediately, and the partial message is abandoned. The full sequence restarts, beginning with CLEAR, after release.
- Scores changing in the same cycle as the IDLE decision: the value sampled that cycle is used.

## Structure
- Package lcd_msg_pkg holds:
  - status encodings (ST_TIE, ST_P1, ST_P2, ST_NONE);
  - FSM state enum;
  - MSG_LEN=16;
  - ASCII constants for the three strings.
- Sub-module lcd_msg_rom: combinational (msg_sel[1:0], idx[3:0]) → char[7:0]; returns 8'h20 for msg_sel=11.
- The top level feeds lcd_write_en and lcd_data to the lcd instance, and uses `~resetn | lcd_clear` as the lcd reset.

## Test plan
Parameters for the bench: CLEAR_WAIT=4, CHAR_GAP=3.
- **Release from reset**, scores 0/0:
  - lcd_clear pulse 1 cycle after release.
  - 16 writes spaced 4 cycles apart: "SCORE IS TIED" then three 8'h20.
  - done at cycle 2+4+64=70 after the IDLE decision; leader=00.
- **Lead change**: player1_score=5, player2_score=3 while idle with leader=00:
  - clear, then "PLAYER 1 WINNING" byte-exact; leader=01.
- **Mid-message change**: during write 7 of the P1 message, set player2_score=9:
  - remaining chars still come from the P1 string; done; leader=01.
  - next cycle in IDLE starts CLEAR; the new message is "PLAYER 2 WINNING"; leader=10.
- **No change**: scores change 5/3 → 8/3 while leader=01:
  - no clear pulse and no writes; busy stays 0.
- **Reset mid-message** at write 10:
  - all outputs zero in the same cycle; leader=11.
  - after release, the full 16-char message replays from CLEAR.
- **Width boundary**: scores 1023 vs 1022:
  - P1 message; then 1022 vs 1023 gives the P2 message, confirming the unsigned full-width compare.
